// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end: widths, FSM states, opcodes.
package spi_pkg;

    localparam int CMD_W  = 10;  // 2-bit opcode + 8-bit payload
    localparam int DATA_W = 8;   // read byte returned on MISO
    localparam int CNT_W  = 4;   // bit counter, must hold CMD_W-1

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        SEND      = 3'd5
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial datapath: SIPO for incoming command bits, PISO for the outgoing read
// byte, and one bit counter shared by both directions (never active together).
module spi_shift_reg #(
    parameter int CMD_W  = 10,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,       // drop partial frame, counter to 0, MISO low
    input  logic              rx_start,  // sample the leading bit, counter to 0
    input  logic              rx_en,     // sample one more bit, counter + 1
    input  logic              mosi,
    input  logic              tx_load,   // latch read byte and drive its MSB
    input  logic [DATA_W-1:0] tx_byte,
    input  logic              tx_en,     // drive the next byte bit while any remain
    output logic [CMD_W-1:0]  rx_word,   // word completed by the bit currently on MOSI
    output logic [CNT_W-1:0]  cnt,
    output logic              miso
);

    localparam logic [CNT_W-1:0] TX_BITS = CNT_W'(DATA_W);

    // Only the bits already received are stored; the newest bit comes straight
    // from MOSI so the top can capture the full word on the edge sampling bit 0.
    logic [CMD_W-2:0]  rx_shift_reg;
    logic [DATA_W-2:0] tx_shift_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              miso_reg;

    assign rx_word = {rx_shift_reg, mosi};
    assign cnt     = cnt_reg;
    assign miso    = miso_reg;

    // Shift/count register bank; MISO falls back to 0 unless a byte bit is driven.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            cnt_reg      <= '0;
            miso_reg     <= 1'b0;
        end else if (tx_load) begin
            tx_shift_reg <= tx_byte[DATA_W-2:0];
            miso_reg     <= tx_byte[DATA_W-1];
            cnt_reg      <= CNT_W'(1);
        end else if (rx_start) begin
            rx_shift_reg <= {rx_shift_reg[CMD_W-3:0], mosi};
            cnt_reg      <= '0;
            miso_reg     <= 1'b0;
        end else if (rx_en) begin
            rx_shift_reg <= {rx_shift_reg[CMD_W-3:0], mosi};
            cnt_reg      <= cnt_reg + CNT_W'(1);
            miso_reg     <= 1'b0;
        end else if (tx_en && (cnt_reg < TX_BITS)) begin
            miso_reg     <= tx_shift_reg[DATA_W-2];
            tx_shift_reg <= {tx_shift_reg[DATA_W-3:0], 1'b0};
            cnt_reg      <= cnt_reg + CNT_W'(1);
        end else begin
            miso_reg     <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end for the RAM command port: frames MOSI into command words,
// strobes rx_valid, and returns the RAM read byte on MISO after a read-data command.
module spi_slave_ctrl #(
    parameter int CMD_W  = spi_pkg::CMD_W,
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [CMD_W-1:0]  rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    import spi_pkg::*;

    // Counter milestones: after the leading bit the counter runs 0..CMD_W-2
    // for the remaining bits and parks at CMD_W-1 once the word is complete.
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(CMD_W - 2);
    localparam logic [CNT_W-1:0] RX_DONE = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);

    state_t             state_reg, state_next;
    logic               rd_addr_seen_reg, rd_addr_seen_next;
    logic [CMD_W-1:0]   rx_data_reg;
    logic               rx_valid_reg;

    logic               clr, rx_start, rx_en, tx_load, tx_en, word_done;
    logic [CMD_W-1:0]   rx_word;
    logic [CNT_W-1:0]   cnt;

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;

    spi_shift_reg #(
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rx_start (rx_start),
        .rx_en    (rx_en),
        .mosi     (MOSI),
        .tx_load  (tx_load),
        .tx_byte  (tx_data),
        .tx_en    (tx_en),
        .rx_word  (rx_word),
        .cnt      (cnt),
        .miso     (MISO)
    );

    // Next-state logic and datapath controls; SS_n high aborts any frame.
    always_comb begin
        state_next        = state_reg;
        rd_addr_seen_next = rd_addr_seen_reg;
        clr               = 1'b0;
        rx_start          = 1'b0;
        rx_en             = 1'b0;
        tx_load           = 1'b0;
        tx_en             = 1'b0;
        word_done         = 1'b0;

        case (state_reg)
            IDLE: begin
                clr = 1'b1;
                if (!SS_n) begin
                    state_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    clr        = 1'b1;
                    state_next = IDLE;
                end else begin
                    rx_start = 1'b1;
                    if (!MOSI) begin
                        state_next = WRITE;
                    end else if (rd_addr_seen_reg) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    clr        = 1'b1;
                    state_next = IDLE;
                end else if (cnt != RX_DONE) begin
                    rx_en = 1'b1;
                    if (cnt == RX_LAST) begin
                        word_done = 1'b1;
                        if (state_reg == READ_ADD) begin
                            rd_addr_seen_next = 1'b1;
                        end
                    end
                end else if ((state_reg == READ_DATA) && tx_valid) begin
                    tx_load    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (SS_n) begin
                    clr        = 1'b1;
                    state_next = IDLE;
                end else begin
                    tx_en = 1'b1;
                    // The read pair is consumed once its last bit goes out.
                    if (cnt == TX_LAST) begin
                        rd_addr_seen_next = 1'b0;
                    end
                end
            end
            default: begin
                clr        = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, read-pair flag, and the captured word with its one-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rd_addr_seen_reg <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rd_addr_seen_reg <= rd_addr_seen_next;
            rx_valid_reg     <= word_done;
            if (word_done) begin
                rx_data_reg <= rx_word;
            end
        end
    end

endmodule
